alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl -- instruction sequencer in front of an external combinational ALU.
//
// Accepts one 32-bit instruction at a time, reads its operands from an
// internal 8x32 register file (r0 is hard zero), drives the external ALU,
// captures the result and presents it on a valid/ready result port. The
// destination register is written when the result is handed off.
// Sequence: IDLE -> DECODE -> EXEC -> RESP -> IDLE. Illegal ops skip EXEC.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : instruction handshake (ready only in IDLE)
//   instr             : instruction word
//   alu_a, alu_b      : operands to the external ALU (registered)
//   alu_oper          : ALU operation code (registered)
//   alu_sum, alu_z    : combinational result / zero flag from the ALU
//   out_valid/out_ready : result handshake
//   out_rd, out_data, out_z, illegal : result fields, stable while in RESP
// ---------------------------------------------------------------------------
module alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_oper,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_z,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]       state_q, state_d;
  // Instruction word minus bits [17:16], which carry no field.
  logic [29:0]      instr_q, instr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_oper_q, alu_oper_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_z_q, out_z_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] regs_q [8];

  // Field decode of the held instruction.
  logic [3:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic        imm_sel;
  logic [15:0] imm;

  assign op      = instr_q[29:26];
  assign rd      = instr_q[25:23];
  assign rs1     = instr_q[22:20];
  assign rs2     = instr_q[19:17];
  assign imm_sel = instr_q[16];
  assign imm     = instr_q[15:0];

  logic [WIDTH-1:0] rs1_val, imm_ext, src2;

  assign rs1_val = regs_q[rs1];
  assign imm_ext = {{(WIDTH-16){1'b0}}, imm};
  assign src2    = imm_sel ? imm_ext : regs_q[rs2];

  // Operand routing: logic ops take (rs1, src2); shifts swap so the ALU
  // shifts alu_b by alu_a[4:0]; LUI passes the immediate on alu_b.
  logic             legal;
  logic [3:0]       dec_oper;
  logic [WIDTH-1:0] dec_a, dec_b;

  always_comb begin
    legal    = 1'b1;
    dec_oper = 4'b0000;
    dec_a    = rs1_val;
    dec_b    = src2;
    case (op)
      4'd0: dec_oper = 4'b0000;
      4'd1: dec_oper = 4'b0100;
      4'd2: dec_oper = 4'b0001;
      4'd3: dec_oper = 4'b0101;
      4'd4: dec_oper = 4'b0010;
      4'd5: begin
        dec_oper = 4'b0110;
        dec_a    = '0;
        dec_b    = imm_ext;
      end
      4'd6: begin
        dec_oper = 4'b0011;
        dec_a    = src2;
        dec_b    = rs1_val;
      end
      4'd7: begin
        dec_oper = 4'b0111;
        dec_a    = src2;
        dec_b    = rs1_val;
      end
      4'd8: begin
        dec_oper = 4'b1111;
        dec_a    = src2;
        dec_b    = rs1_val;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_oper_d = alu_oper_q;
    out_data_d = out_data_q;
    out_z_d    = out_z_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = {instr[31:18], instr[15:0]};
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          alu_a_d    = dec_a;
          alu_b_d    = dec_b;
          alu_oper_d = dec_oper;
          state_d    = S_EXEC;
        end else begin
          illegal_d  = 1'b1;
          out_data_d = '0;
          out_z_d    = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_EXEC: begin
        out_data_d = alu_sum;
        out_z_d    = alu_z;
        illegal_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_oper_q <= 4'b0000;
      out_data_q <= '0;
      out_z_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_oper_q <= alu_oper_d;
      out_data_q <= out_data_d;
      out_z_q    <= out_z_d;
      illegal_q  <= illegal_d;
    end
  end

  // Write-back happens on the result handshake, so the next instruction's
  // DECODE already sees the new value. r0 is never written.
  logic wr_en;
  assign wr_en = (state_q == S_RESP) && out_ready && !illegal_q && (rd != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd] <= out_data_q;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_oper  = alu_oper_q;
  assign out_rd    = rd;
  assign out_data  = out_data_q;
  assign out_z     = out_z_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl -- self-checking bench for alu_ctrl.
// Provides a behavioural external ALU, a directed sequence with literal
// expectations, and randomized instructions checked every cycle against a
// reference model of the register file and instruction results.
// ---------------------------------------------------------------------------
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid, alu_z, out_z, illegal;
  logic [31:0] alu_a, alu_b, alu_sum, out_data;
  logic [3:0]  alu_oper;
  logic [2:0]  out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
    .alu_sum(alu_sum), .alu_z(alu_z), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_z(out_z), .illegal(illegal)
  );

  // External combinational ALU.
  always_comb begin
    case (alu_oper)
      4'b0000: alu_sum = alu_a + alu_b;
      4'b0100: alu_sum = alu_a - alu_b;
      4'b0001: alu_sum = alu_a & alu_b;
      4'b0101: alu_sum = alu_a | alu_b;
      4'b0010: alu_sum = alu_a ^ alu_b;
      4'b0110: alu_sum = alu_b << 16;
      4'b0011: alu_sum = alu_b << alu_a[4:0];
      4'b0111: alu_sum = alu_b >> alu_a[4:0];
      4'b1111: alu_sum = $signed(alu_b) >>> alu_a[4:0];
      default: alu_sum = '0;
    endcase
  end
  assign alu_z = (alu_sum == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic isel, input logic [15:0] imm);
    return {op, rd, rs1, rs2, isel, 2'b00, imm};
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_r [8];
  bit          m_pend = 1'b0;
  bit          m_legal;
  int          m_age, m_lat;
  logic [2:0]  m_rd;
  logic [31:0] m_res, m_a, m_b, cur_a, cur_b;
  logic        m_z;
  logic [3:0]  m_oper, cur_oper;

  task automatic model_accept(input logic [31:0] w);
    logic [3:0]  op   = w[31:28];
    logic [31:0] imm  = {16'h0, w[15:0]};
    logic [31:0] a    = m_r[w[24:22]];
    logic [31:0] src2 = w[18] ? imm : m_r[w[21:19]];
    m_legal = (op <= 4'd8);
    m_lat   = m_legal ? 3 : 2;
    m_rd    = w[27:25];
    m_age   = 1;
    m_pend  = 1'b1;
    m_a     = a;
    m_b     = src2;
    case (op)
      4'd0: begin m_res = a + src2; m_oper = 4'b0000; end
      4'd1: begin m_res = a - src2; m_oper = 4'b0100; end
      4'd2: begin m_res = a & src2; m_oper = 4'b0001; end
      4'd3: begin m_res = a | src2; m_oper = 4'b0101; end
      4'd4: begin m_res = a ^ src2; m_oper = 4'b0010; end
      4'd5: begin m_res = imm << 16; m_oper = 4'b0110; m_a = 0; m_b = imm; end
      4'd6: begin m_res = a << src2[4:0]; m_oper = 4'b0011; m_a = src2; m_b = a; end
      4'd7: begin m_res = a >> src2[4:0]; m_oper = 4'b0111; m_a = src2; m_b = a; end
      4'd8: begin m_res = $signed(a) >>> src2[4:0]; m_oper = 4'b1111; m_a = src2; m_b = a; end
      default: begin m_res = 0; m_oper = cur_oper; m_a = cur_a; m_b = cur_b; end
    endcase
    m_z = m_legal && (m_res == 32'd0);
  endtask

  // Compare process: every falling edge, DUT outputs vs. model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 8; i++) m_r[i] = 32'd0;
        m_pend = 1'b0; cur_a = 0; cur_b = 0; cur_oper = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_oper", alu_oper, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_illegal", illegal, 0);
      end else begin
        if (m_pend && m_legal && m_age >= 2) begin
          cur_a = m_a; cur_b = m_b; cur_oper = m_oper;
        end
        chk("in_ready", in_ready, !m_pend);
        chk("out_valid", out_valid, m_pend && m_age >= m_lat);
        chk("alu_a", alu_a, cur_a);
        chk("alu_b", alu_b, cur_b);
        chk("alu_oper", alu_oper, cur_oper);
        if (m_pend && m_age >= m_lat) begin
          chk("out_rd", out_rd, m_rd);
          chk("out_data", out_data, m_res);
          chk("out_z", out_z, m_z);
          chk("illegal", illegal, !m_legal);
        end
        if (m_pend) begin
          if (m_age >= m_lat && out_ready) begin
            if (m_legal && m_rd != 3'd0) m_r[m_rd] = m_res;
            m_pend = 1'b0;
          end else begin
            m_age++;
          end
        end else if (in_valid) begin
          model_accept(instr);
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] r_data, r_a, r_b;
  logic [3:0]  r_oper;
  logic [2:0]  r_rd;
  logic        r_z, r_ill;
  int          r_lat;

  // Issue one instruction, wait for the result, stall, then hand it off.
  task automatic run(input logic [31:0] ins, input int stall, input bit chk_stall);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
    chk("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1; instr = ins;
    @(posedge clk); #2;
    r_lat = 1;
    in_valid = 1'($urandom_range(0, 1));  // ignored while busy
    instr = $urandom;
    while (!out_valid && r_lat < 20) begin @(posedge clk); #2; r_lat++; end
    in_valid = 1'b0;
    chk("out_valid_timeout", out_valid, 1);
    r_data = out_data; r_z = out_z; r_ill = illegal; r_rd = out_rd;
    r_a = alu_a; r_b = alu_b; r_oper = alu_oper;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #2;
      if (chk_stall) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_illegal", illegal, r_ill);
        chk("stall_out_data", out_data, r_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic reset_mid(input int k);
    in_valid = 1'b1; instr = enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055);
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int s = 0; s < k; s++) begin @(posedge clk); #2; end
    rst = 1'b1; #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_alu_b", alu_b, 0);
    chk("async_rst_out_rd", out_rd, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    run(enc(4'd3, 3'd3, 3'd1, 3'd0, 1'b0, 16'h0), 0, 0);
    chk("rst_r1_cleared", r_data, 32'h0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run(enc(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0072), 0, 0);
    chk("add_data", r_data, 32'h72);
    chk("add_z", r_z, 0);
    chk("add_rd", r_rd, 1);
    chk("add_oper", r_oper, 4'b0000);
    chk("add_lat", r_lat, 3);
    run(enc(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0021), 1, 0);
    run(enc(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0), 0, 0);
    chk("sub_data", r_data, 32'h51);
    run(enc(4'd4, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0), 0, 0);
    chk("xor_data", r_data, 32'h0);
    chk("xor_z", r_z, 1);
    run(enc(4'd6, 3'd5, 3'd2, 3'd0, 1'b1, 16'h0004), 0, 0);
    chk("sll_alu_a", r_a, 32'h4);
    chk("sll_alu_b", r_b, 32'h21);
    chk("sll_oper", r_oper, 4'b0011);
    chk("sll_data", r_data, 32'h210);
    run(enc(4'd5, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234), 0, 0);
    chk("lui_data", r_data, 32'h12340000);
    run(enc(4'd5, 3'd7, 3'd0, 3'd0, 1'b1, 16'h8000), 0, 0);
    chk("lui_r7", r_data, 32'h80000000);
    run(enc(4'd8, 3'd5, 3'd7, 3'd0, 1'b1, 16'h0004), 0, 0);
    chk("sra_data", r_data, 32'hF8000000);
    run(enc(4'd7, 3'd5, 3'd7, 3'd0, 1'b1, 16'h0004), 0, 0);
    chk("srl_data", r_data, 32'h08000000);
    run(enc(4'hA, 3'd1, 3'd2, 3'd3, 1'b1, 16'hFFFF), 5, 1);
    chk("ill_flag", r_ill, 1);
    chk("ill_data", r_data, 32'h0);
    chk("ill_lat", r_lat, 2);
    run(enc(4'd3, 3'd3, 3'd1, 3'd0, 1'b0, 16'h0), 0, 0);
    chk("ill_no_write_r1", r_data, 32'h72);
    run(enc(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0005), 0, 0);
    run(enc(4'd3, 3'd3, 3'd0, 3'd0, 1'b0, 16'h0), 0, 0);
    chk("r0_zero", r_data, 32'h0);

    for (int k = 0; k < 3; k++) reset_mid(k);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] w;
      logic [3:0]  op;
      w  = $urandom;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      w[31:28] = op;
      run(w, $urandom_range(0, 3), 0);
      chk("rand_lat", r_lat, (op <= 4'd8) ? 3 : 2);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
